wca_tx_dc_correct: RTL and testbench

- Transmit-path DC correction. Adds a programmable per-channel (I, Q) DC bias to interleaved 12-bit TX samples to cancel DAC/LO leakage at the modulator output.
- Sits between the TX interpolation chain and the DAC interface, on the same strobe/iqSel interleaved sample stream the RX DC-offset remover consumes.
- New offset targets are approached by an exact linear ramp rather than a step, so calibration updates cause no transient spur.

---
 rtl/wca_tx_dc_correct.sv | 198 +++++++++++++++++++
 tb/tb_wca_tx_dc_correct.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wca_tx_dc_correct.sv
// Transmit-path DC correction: adds a per-channel (I/Q) bias to an interleaved
// 12-bit sample stream. New bias targets are reached with an exact linear ramp
// of 2^RAMP_LOG2 pair-steps so calibration updates produce no transient spur.
module wca_tx_dc_correct #(
    parameter int RAMP_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        strobe,
    input  logic        iqSel,
    input  logic [11:0] sig_in,
    input  logic [11:0] offset_i,
    input  logic [11:0] offset_q,
    input  logic        load,
    input  logic        clip_clr,
    output logic [11:0] sigout,
    output logic        strobe_out,
    output logic [11:0] cur_i,
    output logic [11:0] cur_q,
    output logic        busy,
    output logic        clipped
);

    // Accumulator carries RAMP_LOG2 fractional bits below the applied integer offset.
    localparam int W = 12 + RAMP_LOG2;
    localparam logic [8:0] CNT_INIT = 9'((1 << RAMP_LOG2) - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RAMP
    } state_t;

    state_t state_q, state_d;

    // Index 0 is the I channel, index 1 is the Q channel.
    logic signed [W-1:0] acc_q  [2];
    logic signed [W-1:0] acc_d  [2];
    logic signed [11:0]  tgt_q  [2];   // pending target, written by load
    logic signed [11:0]  tgt_d  [2];
    logic signed [11:0]  rtgt_q [2];   // target of the ramp currently running
    logic signed [11:0]  rtgt_d [2];
    logic signed [12:0]  step_q [2];
    logic signed [12:0]  step_d [2];
    logic [8:0]          cnt_q, cnt_d;
    logic                pending_q, pending_d;

    logic [11:0]         sigout_q, sigout_d;
    logic                strobe_out_q, strobe_out_d;
    logic                clipped_q, clipped_d;

    logic signed [11:0]  cur      [2];
    logic signed [11:0]  offs     [2];
    logic signed [12:0]  step_new [2];

    assign offs[0] = offset_i;
    assign offs[1] = offset_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            // Applied offset is the floor of the accumulator (drop fraction bits).
            assign cur[gi]      = acc_q[gi][W-1:RAMP_LOG2];
            // Per-pair increment for a fresh ramp, full 13-bit signed difference.
            assign step_new[gi] = {tgt_q[gi][11], tgt_q[gi]} - {cur[gi][11], cur[gi]};
        end
    endgenerate

    // End of an I/Q pair: offsets only ever move after a Q sample.
    logic pair_end;
    assign pair_end = strobe & iqSel;

    // Datapath: add the pre-update offset of the sample's channel, saturate to 12 bits.
    logic signed [11:0] sel_off;
    logic signed [12:0] sum;
    logic               sat_hi, sat_lo;
    logic [11:0]        sat_val;

    always_comb begin
        sel_off = iqSel ? cur[1] : cur[0];
        sum     = {sel_off[11], sel_off} + {sig_in[11], sig_in};
        sat_hi  = (sum[12:11] == 2'b01);
        sat_lo  = (sum[12:11] == 2'b10);
        if (sat_hi) begin
            sat_val = 12'h7FF;
        end else if (sat_lo) begin
            sat_val = 12'h800;
        end else begin
            sat_val = sum[11:0];
        end

        sigout_d     = strobe ? sat_val : sigout_q;
        strobe_out_d = strobe;
        // A saturation on this edge beats a simultaneous clear.
        if (strobe && (sat_hi || sat_lo)) begin
            clipped_d = 1'b1;
        end else if (clip_clr) begin
            clipped_d = 1'b0;
        end else begin
            clipped_d = clipped_q;
        end
    end

    // Ramp control: start a pending ramp at a pair boundary, step once per pair.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        tgt_d     = tgt_q;
        rtgt_d    = rtgt_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;

        case (state_q)
            ST_IDLE: begin
                if (pending_q && pair_end) begin
                    pending_d = 1'b0;
                    if (RAMP_LOG2 == 0) begin
                        // Single-step update: jump straight to the target.
                        for (int ch = 0; ch < 2; ch++) begin
                            acc_d[ch] = W'(tgt_q[ch]);
                        end
                    end else begin
                        for (int ch = 0; ch < 2; ch++) begin
                            step_d[ch] = step_new[ch];
                            rtgt_d[ch] = tgt_q[ch];
                            acc_d[ch]  = acc_q[ch] + W'(step_new[ch]);
                        end
                        cnt_d   = CNT_INIT;
                        state_d = ST_RAMP;
                    end
                end
            end
            ST_RAMP: begin
                if (pair_end) begin
                    if (cnt_q == 9'd1) begin
                        // Last step lands exactly on the target; write it directly.
                        for (int ch = 0; ch < 2; ch++) begin
                            acc_d[ch] = W'(rtgt_q[ch]) <<< RAMP_LOG2;
                        end
                        cnt_d   = 9'd0;
                        state_d = ST_IDLE;
                    end else begin
                        for (int ch = 0; ch < 2; ch++) begin
                            acc_d[ch] = acc_q[ch] + W'(step_q[ch]);
                        end
                        cnt_d = cnt_q - 9'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load is captured after any consumption above, so it is never lost.
        if (load) begin
            tgt_d     = offs;
            pending_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 9'd0;
            pending_q    <= 1'b0;
            sigout_q     <= 12'd0;
            strobe_out_q <= 1'b0;
            clipped_q    <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                acc_q[ch]  <= '0;
                tgt_q[ch]  <= '0;
                rtgt_q[ch] <= '0;
                step_q[ch] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            sigout_q     <= sigout_d;
            strobe_out_q <= strobe_out_d;
            clipped_q    <= clipped_d;
            for (int ch = 0; ch < 2; ch++) begin
                acc_q[ch]  <= acc_d[ch];
                tgt_q[ch]  <= tgt_d[ch];
                rtgt_q[ch] <= rtgt_d[ch];
                step_q[ch] <= step_d[ch];
            end
        end
    end

    assign sigout     = sigout_q;
    assign strobe_out = strobe_out_q;
    assign cur_i      = cur[0];
    assign cur_q      = cur[1];
    assign busy       = (state_q == ST_RAMP) | pending_q;
    assign clipped    = clipped_q;

endmodule

// File: tb/tb_wca_tx_dc_correct.sv
// Bench for wca_tx_dc_correct: a directed vector table on a RAMP_LOG2=2 instance,
// a hand-written single-step sequence on a RAMP_LOG2=0 instance, then random
// stimulus on both against a behavioural model of the offset ramp.
module tb_wca_tx_dc_correct;

    logic        clock = 1'b0;
    logic        reset, strobe, iq_sel, load, clip_clr;
    logic [11:0] sig_in, offset_i, offset_q;

    logic [11:0] so2, ci2, cq2, so0, ci0, cq0;
    logic        sto2, busy2, clip2, sto0, busy0, clip0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    wca_tx_dc_correct #(.RAMP_LOG2(2)) dut (
        .clock(clock), .reset(reset), .strobe(strobe), .iqSel(iq_sel), .sig_in(sig_in),
        .offset_i(offset_i), .offset_q(offset_q), .load(load), .clip_clr(clip_clr),
        .sigout(so2), .strobe_out(sto2), .cur_i(ci2), .cur_q(cq2), .busy(busy2), .clipped(clip2)
    );

    wca_tx_dc_correct #(.RAMP_LOG2(0)) dut0 (
        .clock(clock), .reset(reset), .strobe(strobe), .iqSel(iq_sel), .sig_in(sig_in),
        .offset_i(offset_i), .offset_q(offset_q), .load(load), .clip_clr(clip_clr),
        .sigout(so0), .strobe_out(sto0), .cur_i(ci0), .cur_q(cq0), .busy(busy0), .clipped(clip0)
    );

    typedef struct {
        int rst, stb, iq, sig, ld, oi, oq, cc;
        int so, sto, ci, cq, busy, clip;
    } vec_t;

    vec_t tbl[$];

    function automatic int sx(logic [11:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs; return 1 ns after the active edge.
    task automatic drive(int r, int stb, int iq, int sig, int ld, int oi, int oq, int cc);
        reset    = r[0];
        strobe   = stb[0];
        iq_sel   = iq[0];
        sig_in   = 12'(sig);
        load     = ld[0];
        offset_i = 12'(oi);
        offset_q = 12'(oq);
        clip_clr = cc[0];
        @(posedge clock);
        #1;
    endtask

    task automatic add(int rst, int stb, int iq, int sig, int ld, int oi, int oq, int cc,
                       int so, int sto, int ci, int cq, int bsy, int clp);
        vec_t v;
        v = '{rst, stb, iq, sig, ld, oi, oq, cc, so, sto, ci, cq, bsy, clp};
        tbl.push_back(v);
    endtask

    // Behavioural model: each ramp is start + k/N of the way to the target,
    // floored, for k = 1..N counted in completed I/Q pairs. Index 0: RAMP_LOG2=2, 1: =0.
    int m_so[2], m_sto[2], m_ci[2], m_cq[2], m_clip[2];
    int m_pend[2], m_pi[2], m_pq[2], m_ramp[2], m_k[2];
    int m_si[2], m_sq[2], m_ti[2], m_tq[2];

    function automatic int lg(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic model_step(int d, int r, int stb, int iq, int sig, int ld, int oi, int oq, int cc);
        int s, n, sh;
        sh = lg(d);
        n  = 1 << sh;
        if (r != 0) begin
            m_so[d] = 0; m_sto[d] = 0; m_ci[d] = 0; m_cq[d] = 0; m_clip[d] = 0;
            m_pend[d] = 0; m_ramp[d] = 0; m_k[d] = 0;
            return;
        end
        m_sto[d] = stb;
        if (stb != 0) begin
            s = sig + ((iq != 0) ? m_cq[d] : m_ci[d]);
            if (s > 2047 || s < -2048) begin
                m_clip[d] = 1;
                s = (s > 2047) ? 2047 : -2048;
            end else if (cc != 0) begin
                m_clip[d] = 0;
            end
            m_so[d] = s;
        end else if (cc != 0) begin
            m_clip[d] = 0;
        end
        if (stb != 0 && iq != 0) begin
            if (m_ramp[d] != 0) begin
                m_k[d]++;
            end else if (m_pend[d] != 0) begin
                m_si[d] = m_ci[d]; m_sq[d] = m_cq[d];
                m_ti[d] = m_pi[d]; m_tq[d] = m_pq[d];
                m_k[d] = 1; m_ramp[d] = 1; m_pend[d] = 0;
            end
            if (m_ramp[d] != 0) begin
                m_ci[d] = (m_si[d] * n + m_k[d] * (m_ti[d] - m_si[d])) >>> sh;
                m_cq[d] = (m_sq[d] * n + m_k[d] * (m_tq[d] - m_sq[d])) >>> sh;
                if (m_k[d] == n) m_ramp[d] = 0;
            end
        end
        if (ld != 0) begin
            m_pend[d] = 1; m_pi[d] = oi; m_pq[d] = oq;
        end
    endtask

    initial begin
        // rst stb iq sig  ld oi  oq  cc | so  sto ci  cq  busy clip
        add(0, 1, 0, 100,   0, 0, 0, 0,   100, 1, 0, 0, 0, 0);
        add(0, 1, 1, -50,   0, 0, 0, 0,   -50, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0,     1, 100, -40, 0, -50, 0, 0, 0, 1, 0);
        add(0, 1, 0, 10,    0, 0, 0, 0,   10, 1, 0, 0, 1, 0);
        add(0, 1, 1, 10,    0, 0, 0, 0,   10, 1, 25, -10, 1, 0);
        add(0, 1, 0, 10,    0, 0, 0, 0,   35, 1, 25, -10, 1, 0);
        add(0, 1, 1, 10,    0, 0, 0, 0,   0, 1, 50, -20, 1, 0);
        add(0, 1, 0, 10,    0, 0, 0, 0,   60, 1, 50, -20, 1, 0);
        add(0, 1, 1, 10,    0, 0, 0, 0,   -10, 1, 75, -30, 1, 0);
        add(0, 1, 0, 10,    0, 0, 0, 0,   85, 1, 75, -30, 1, 0);
        add(0, 1, 1, 10,    0, 0, 0, 0,   -20, 1, 100, -40, 0, 0);
        add(0, 1, 0, 2000,  0, 0, 0, 0,   2047, 1, 100, -40, 0, 1);
        add(0, 0, 0, 0,     0, 0, 0, 1,   2047, 0, 100, -40, 0, 0);
        add(0, 1, 1, -2048, 0, 0, 0, 0,   -2048, 1, 100, -40, 0, 1);
        add(0, 0, 0, 0,     0, 0, 0, 1,   -2048, 0, 100, -40, 0, 0);
        add(0, 1, 0, 1990,  0, 0, 0, 1,   2047, 1, 100, -40, 0, 1);
        add(0, 1, 1, -100,  0, 0, 0, 0,   -140, 1, 100, -40, 0, 1);
        // reset, then a 0 -> -200 ramp with a load of 100 arriving mid-ramp
        add(1, 0, 0, 0,     0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0,     1, -200, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   0, 1, 0, 0, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   0, 1, -50, 0, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   -50, 1, -50, 0, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   0, 1, -100, 0, 1, 0);
        add(0, 0, 0, 0,     1, 100, 0, 0, 0, 0, -100, 0, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   -100, 1, -100, 0, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   0, 1, -150, 0, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   -150, 1, -150, 0, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   0, 1, -200, 0, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   -200, 1, -200, 0, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   0, 1, -125, 0, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   -125, 1, -125, 0, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   0, 1, -50, 0, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   -50, 1, -50, 0, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   0, 1, 25, 0, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   25, 1, 25, 0, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   0, 1, 100, 0, 0, 0);
        add(0, 1, 0, 5,     0, 0, 0, 0,   105, 1, 100, 0, 0, 0);
        // reset mid-ramp with a target pending
        add(0, 0, 0, 0,     1, 40, 40, 0,  105, 0, 100, 0, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   100, 1, 100, 0, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   0, 1, 85, 10, 1, 0);
        add(0, 0, 0, 0,     1, -500, 0, 0, 0, 0, 85, 10, 1, 0);
        add(1, 0, 0, 0,     0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 33,    0, 0, 0, 0,   33, 1, 0, 0, 0, 0);
        add(0, 1, 1, -33,   0, 0, 0, 0,   -33, 1, 0, 0, 0, 0);
        // non-divisible step: applied offset is the floor of the exact ramp
        add(0, 0, 0, 0,     1, 3, -3, 0,  -33, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   0, 1, 0, 0, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   0, 1, 0, -1, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   0, 1, 0, -1, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   -1, 1, 1, -2, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   1, 1, 1, -2, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   -2, 1, 2, -3, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0, 0,   2, 1, 2, -3, 1, 0);
        add(0, 1, 1, 0,     0, 0, 0, 0,   -3, 1, 3, -3, 0, 0);

        // Reset state of both instances.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_sigout", sx(so2), 0);
        chk("rst_strobe_out", int'(sto2), 0);
        chk("rst_cur_i", sx(ci2), 0);
        chk("rst_cur_q", sx(cq2), 0);
        chk("rst_busy", int'(busy2), 0);
        chk("rst_clipped", int'(clip2), 0);
        chk("rst0_busy", int'(busy0), 0);
        chk("rst0_cur_i", sx(ci0), 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stb, tbl[i].iq, tbl[i].sig, tbl[i].ld, tbl[i].oi, tbl[i].oq, tbl[i].cc);
            $display("vec %0d: stb=%0d iq=%0d sig=%0d ld=%0d -> sigout=%0d cur=(%0d,%0d) busy=%0d clipped=%0d",
                     i, tbl[i].stb, tbl[i].iq, tbl[i].sig, tbl[i].ld, sx(so2), sx(ci2), sx(cq2), busy2, clip2);
            chk($sformatf("vec%0d_sigout", i), sx(so2), tbl[i].so);
            chk($sformatf("vec%0d_strobe_out", i), int'(sto2), tbl[i].sto);
            chk($sformatf("vec%0d_cur_i", i), sx(ci2), tbl[i].ci);
            chk($sformatf("vec%0d_cur_q", i), sx(cq2), tbl[i].cq);
            chk($sformatf("vec%0d_busy", i), int'(busy2), tbl[i].busy);
            chk($sformatf("vec%0d_clipped", i), int'(clip2), tbl[i].clip);
        end

        // Single-step instance: load -7 lands right after the next Q strobe.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, -7, 0, 0);
        $display("r0 load -7: cur_i=%0d busy=%0d", sx(ci0), busy0);
        chk("r0_load_busy", int'(busy0), 1);
        chk("r0_load_cur_i", sx(ci0), 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        $display("r0 I strobe: cur_i=%0d busy=%0d", sx(ci0), busy0);
        chk("r0_i_busy", int'(busy0), 1);
        chk("r0_i_cur_i", sx(ci0), 0);
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        $display("r0 Q strobe: cur_i=%0d busy=%0d", sx(ci0), busy0);
        chk("r0_q_cur_i", sx(ci0), -7);
        chk("r0_q_busy", int'(busy0), 0);
        drive(0, 1, 0, 10, 0, 0, 0, 0);
        $display("r0 I strobe sig=10: sigout=%0d", sx(so0));
        chk("r0_sigout", sx(so0), 3);

        // Random stimulus on both instances against the model.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        model_step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        model_step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            int r, stb, iq, sig, ld, oi, oq, cc;
            r   = ($urandom_range(0, 999) < 3) ? 1 : 0;
            stb = ($urandom_range(0, 9) < 7) ? 1 : 0;
            iq  = ($urandom_range(0, 9) < 5) ? 1 : 0;
            sig = int'($urandom_range(0, 4095)) - 2048;
            ld  = ($urandom_range(0, 99) < 5) ? 1 : 0;
            oi  = int'($urandom_range(0, 4095)) - 2048;
            oq  = int'($urandom_range(0, 4095)) - 2048;
            cc  = ($urandom_range(0, 99) < 5) ? 1 : 0;
            drive(r, stb, iq, sig, ld, oi, oq, cc);
            model_step(0, r, stb, iq, sig, ld, oi, oq, cc);
            model_step(1, r, stb, iq, sig, ld, oi, oq, cc);
            if (ld != 0)
                $display("rnd %0d: load (%0d,%0d) cur2=(%0d,%0d) cur0=(%0d,%0d)",
                         c, oi, oq, sx(ci2), sx(cq2), sx(ci0), sx(cq0));
            chk($sformatf("rnd%0d_r2_sigout", c), sx(so2), m_so[0]);
            chk($sformatf("rnd%0d_r2_strobe_out", c), int'(sto2), m_sto[0]);
            chk($sformatf("rnd%0d_r2_cur_i", c), sx(ci2), m_ci[0]);
            chk($sformatf("rnd%0d_r2_cur_q", c), sx(cq2), m_cq[0]);
            chk($sformatf("rnd%0d_r2_busy", c), int'(busy2), (m_ramp[0] | m_pend[0]));
            chk($sformatf("rnd%0d_r2_clipped", c), int'(clip2), m_clip[0]);
            chk($sformatf("rnd%0d_r0_sigout", c), sx(so0), m_so[1]);
            chk($sformatf("rnd%0d_r0_strobe_out", c), int'(sto0), m_sto[1]);
            chk($sformatf("rnd%0d_r0_cur_i", c), sx(ci0), m_ci[1]);
            chk($sformatf("rnd%0d_r0_cur_q", c), sx(cq0), m_cq[1]);
            chk($sformatf("rnd%0d_r0_busy", c), int'(busy0), (m_ramp[1] | m_pend[1]));
            chk($sformatf("rnd%0d_r0_clipped", c), int'(clip0), m_clip[1]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
